branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held per mispredict (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 16, giving the statistics counter width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port CLK  in  1  system clock.
REQ-005 SHALL have port nRST  in  1  synchronous active-low reset.
REQ-006 SHALL have port res_valid  in  1  branch FU result valid.
REQ-007 SHALL have port res_ready  out  1  result accepted when res_valid&&res_ready.
REQ-008 SHALL have port res_taken  in  1  resolved branch outcome.
REQ-009 SHALL have port res_target  in  32  resolved taken target (current_pc+imm).
REQ-010 SHALL have port res_pc  in  32  PC of the resolved branch.
REQ-011 SHALL have port pred_taken  in  1  direction predicted at fetch.
REQ-012 SHALL have port pred_target  in  32  target predicted at fetch.
REQ-013 SHALL have port flush  out  1  squash younger in-flight instructions.
REQ-014 SHALL have port redirect_valid  out  1  corrected fetch PC valid.
REQ-015 SHALL have port redirect_pc  out  32  corrected fetch PC.
REQ-016 SHALL have port redirect_ready  in  1  fetch accepts the redirect.
REQ-017 SHALL have port upd_valid  out  1  single-cycle predictor update pulse.
REQ-018 SHALL have ports upd_pc (32), upd_taken (1) and upd_target (32), all out, carrying the predictor update payload.
REQ-019 SHALL have ports branch_cnt and mispred_cnt, both out, CNT_W wide, carrying saturating statistics.

Function
REQ-020 SHALL implement FSM states IDLE, FLUSH and REDIRECT.
REQ-021 In IDLE, res_ready SHALL be 1; in FLUSH and REDIRECT, res_ready SHALL be 0.
REQ-022 On acceptance, mispredict SHALL be computed as (res_taken!=pred_taken) || (res_taken && res_target!=pred_target).
REQ-023 The correct PC SHALL be res_taken ? res_target : res_pc+4, with pc+4 computed modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-024 Every accepted result SHALL produce, on the next cycle, upd_valid=1 for exactly one cycle with upd_pc=res_pc, upd_taken=res_taken and upd_target=res_target.
REQ-025 Every accepted result SHALL increment branch_cnt; a mispredict SHALL also increment mispred_cnt; both counters SHALL saturate at all-ones.
REQ-026 On a correct prediction, the FSM SHALL stay in IDLE and back-to-back results SHALL be accepted every cycle.
REQ-027 On a mispredict accepted at cycle N, the FSM SHALL register the correct PC into redirect_pc and enter FLUSH at N+1.
REQ-028 flush SHALL be 1 during cycles N+1 .. N+FLUSH_CYCLES, then the FSM SHALL enter REDIRECT.
REQ-029 In REDIRECT, redirect_valid SHALL be 1 with redirect_pc stable until the first cycle in which redirect_ready=1; the FSM SHALL then return to IDLE on the next edge.
REQ-030 redirect_ready SHALL be ignored outside REDIRECT.
REQ-031 res_valid SHALL be ignored while res_ready=0; upstream holds its payload and no result is dropped or double-counted.
REQ-032 When redirect_ready=1 and res_valid=1 coincide in REDIRECT, the result SHALL NOT be accepted that cycle; it is accepted earliest in the following IDLE cycle.
REQ-033 flush and redirect_valid SHALL never be 1 in the same cycle.
REQ-034 All outputs SHALL be driven from registers or from FSM state only, with no combinational input-to-output path except none; res_ready SHALL be a function of state only.

Reset
REQ-035 When nRST=0 at a clock edge, the block SHALL set state IDLE, flush=0, redirect_valid=0, redirect_pc=0, upd_valid=0, upd_pc=0, upd_taken=0, upd_target=0, branch_cnt=0, mispred_cnt=0 and the flush counter to 0.
REQ-036 A reset during FLUSH or REDIRECT SHALL drop flush and redirect_valid at that same edge with no pending redirect retained.
REQ-037 During reset, res_ready SHALL read 0.

Structure
REQ-038 The state enum (brres_state_t) and the 32-bit word_t SHALL reside in types_pkg.
REQ-039 The ports SHALL be bundled as interface branch_resolve_if, with modports for the branch FU, fetch and the predictor.
REQ-040 The two statistics counters SHALL be instances of one sub-module, sat_counter, with parameter W and inputs inc and nRST.
REQ-041 The flush down-counter SHALL be 4 bits wide and local to the block.

Verification
REQ-042 Correct-prediction test: pc=0x100, taken=1, target=0x164, pred_taken=1, pred_target=0x164 -> no flush; upd_valid pulse at N+1 with upd_target=0x164; branch_cnt=1, mispred_cnt=0.
REQ-043 Direction-mispredict test: pc=0x200, taken=0, pred_taken=1 -> flush at N+1..N+2, redirect_valid at N+3 with redirect_pc=0x204, res_ready=0 throughout.
REQ-044 Target-mispredict with back-pressure test: taken=1, target=0x300, pred_target=0x310, redirect_ready held 0 for 5 cycles -> redirect_pc=0x300 stable across those cycles; IDLE one edge after redirect_ready=1.
REQ-045 Wrap-around test: pc=0xFFFFFFFC, taken=0, pred_taken=1 -> redirect_pc=0x00000000.
REQ-046 Reset mid-operation test: nRST=0 in the 2nd FLUSH cycle -> next cycle flush=0, redirect_valid=0, counters=0, res_ready=0 during reset and 1 after release.
REQ-047 Saturation test: with CNT_W=4, send 20 mispredicts with res_valid held high -> mispred_cnt=0xF, branch_cnt=0xF, and each result is accepted exactly once.

Source files
------------

// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : types_pkg
//  Description : Shared types for the branch resolution block: the 32-bit
//                machine word, the resolver FSM state encoding and helpers
//                for the mispredict test and the corrected fetch PC.
//  Revision    : 1.0  initial release
// ============================================================================
package types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } brres_state_t;

    localparam word_t c_insn_bytes = 32'd4;

    // A taken branch is also wrong if it was predicted taken to the wrong place.
    function automatic logic is_mispredict(input logic  taken,
                                           input word_t target,
                                           input logic  p_taken,
                                           input word_t p_target);
        return (taken != p_taken) || (taken && (target != p_target));
    endfunction

    // Fall-through wraps modulo 2^32 by virtue of the 32-bit result.
    function automatic word_t correct_pc(input logic  taken,
                                         input word_t target,
                                         input word_t pc);
        return taken ? target : (pc + c_insn_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_if
//  Description : Signal bundle around branch_resolve with views for the
//                branch functional unit (result producer), the fetch unit
//                (redirect consumer), the predictor (update/statistics
//                consumer) and the resolver itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface branch_resolve_if #(
    parameter int CNT_W = 16
);
    import types_pkg::*;

    logic             res_valid;
    logic             res_ready;
    logic             res_taken;
    word_t            res_target;
    word_t            res_pc;
    logic             pred_taken;
    word_t            pred_target;
    logic             flush;
    logic             redirect_valid;
    word_t            redirect_pc;
    logic             redirect_ready;
    logic             upd_valid;
    word_t            upd_pc;
    logic             upd_taken;
    word_t            upd_target;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport branch_fu (
        output res_valid, res_taken, res_target, res_pc, pred_taken, pred_target,
        input  res_ready, flush
    );

    modport fetch (
        input  flush, redirect_valid, redirect_pc,
        output redirect_ready
    );

    modport predictor (
        input  upd_valid, upd_pc, upd_taken, upd_target, branch_cnt, mispred_cnt
    );

    modport resolver (
        input  res_valid, res_taken, res_target, res_pc, pred_taken, pred_target,
               redirect_ready,
        output res_ready, flush, redirect_valid, redirect_pc,
               upd_valid, upd_pc, upd_taken, upd_target, branch_cnt, mispred_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that sticks at all-ones.
//  Ports       : clk   - clock
//                nRST  - synchronous active-low reset (clears count)
//                inc   - add one this cycle (ignored once saturated)
//                count - current value
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : Accepts resolved branch results, emits a one-cycle predictor
//                update per result, keeps saturating branch/mispredict
//                statistics and, on a mispredict, holds flush for
//                FLUSH_CYCLES cycles then offers the corrected PC to fetch
//                until it is taken.
//  Ports       : CLK, nRST                     - clock, sync active-low reset
//                res_valid/res_ready           - result handshake
//                res_taken/res_target/res_pc   - resolved outcome
//                pred_taken/pred_target        - fetch-time prediction
//                flush                         - squash younger instructions
//                redirect_valid/_pc/_ready     - corrected fetch PC handshake
//                upd_valid/_pc/_taken/_target  - predictor update pulse
//                branch_cnt/mispred_cnt        - saturating statistics
//  Revision    : 1.0  initial release
// ============================================================================
module branch_resolve
    import types_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    input  logic [31:0]      res_pc,
    input  logic             pred_taken,
    input  logic [31:0]      pred_target,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [31:0]      upd_target,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    // Counter is loaded with FLUSH_CYCLES-1 on entry to FLUSH; FLUSH lasts
    // until it has been seen at zero, giving exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] c_flush_load = 4'(FLUSH_CYCLES - 1);

    brres_state_t r_state;
    logic [3:0]   r_flush_cnt;
    logic         r_out_of_reset;
    logic         r_flush;
    logic         r_redirect_valid;
    word_t        r_redirect_pc;
    logic         r_upd_valid;
    word_t        r_upd_pc;
    logic         r_upd_taken;
    word_t        r_upd_target;

    logic         w_accept;
    logic         w_mispredict;
    word_t        w_correct_pc;

    // r_out_of_reset is a registered copy of nRST, so ready stays a pure
    // function of flops and reads 0 from the first reset edge onwards.
    assign res_ready    = (r_state == IDLE) && r_out_of_reset;
    assign w_accept     = res_valid && res_ready;
    assign w_mispredict = is_mispredict(res_taken, res_target, pred_taken, pred_target);
    assign w_correct_pc = correct_pc(res_taken, res_target, res_pc);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state          <= IDLE;
            r_flush_cnt      <= 4'd0;
            r_out_of_reset   <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_upd_valid      <= 1'b0;
            r_upd_pc         <= '0;
            r_upd_taken      <= 1'b0;
            r_upd_target     <= '0;
        end else begin
            r_out_of_reset <= 1'b1;
            r_upd_valid    <= w_accept;
            if (w_accept) begin
                r_upd_pc     <= res_pc;
                r_upd_taken  <= res_taken;
                r_upd_target <= res_target;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept && w_mispredict) begin
                        r_state       <= FLUSH;
                        r_flush       <= 1'b1;
                        r_flush_cnt   <= c_flush_load;
                        r_redirect_pc <= w_correct_pc;
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == 4'd0) begin
                        r_state          <= REDIRECT;
                        r_flush          <= 1'b0;
                        r_redirect_valid <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        r_state          <= IDLE;
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= IDLE;
                    r_flush          <= 1'b0;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (CLK),
        .nRST  (nRST),
        .inc   (w_accept),
        .count (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk   (CLK),
        .nRST  (nRST),
        .inc   (w_accept && w_mispredict),
        .count (mispred_cnt)
    );

    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign upd_valid      = r_upd_valid;
    assign upd_pc         = r_upd_pc;
    assign upd_taken      = r_upd_taken;
    assign upd_target     = r_upd_target;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Self-checking bench for branch_resolve (FLUSH_CYCLES=2,
//                CNT_W=4). Expected behaviour comes from a transaction-level
//                model: mispredict/correct-PC rules, a timeline of
//                FLUSH_CYCLES flush cycles then redirect, and counters as
//                min(count, 2^CNT_W-1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_resolve;

    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          nRST;
    logic          res_valid;
    logic          res_ready;
    logic          res_taken;
    logic [31:0]   res_target;
    logic [31:0]   res_pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          flush;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          redirect_ready;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic          upd_taken;
    logic [31:0]   upd_target;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_br  = 0;
    int model_mis = 0;
    int accepted_total = 0;
    int upd_pulses = 0;

    always #5 clk = ~clk;

    branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .CLK            (clk),
        .nRST           (nRST),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_pc         (res_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    // Independent tally of update pulses, compared with accepted results.
    always @(negedge clk) if (upd_valid === 1'b1) upd_pulses++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic int sat(input int n);
        return (n > SAT) ? SAT : n;
    endfunction

    // One branch transaction, entered while the DUT sits in IDLE. hold keeps
    // res_valid asserted throughout (the next transaction is presented as
    // soon as the DUT is back in IDLE).
    task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt,
                        input int rr_delay, input bit hold);
        bit          mis;
        logic [31:0] good;
        mis  = (tk != ptk) || (tk && (tgt != ptgt));
        good = tk ? tgt : pc + 32'd4;

        res_pc = pc; res_taken = tk; res_target = tgt;
        pred_taken = ptk; pred_target = ptgt; res_valid = 1'b1;
        chk("ready_idle", 32'(res_ready), 32'd1);
        step();
        model_br++; accepted_total++;
        if (mis) model_mis++;
        if (!hold) res_valid = 1'b0;

        chk("upd_valid", 32'(upd_valid), 32'd1);
        chk("upd_pc", upd_pc, pc);
        chk("upd_taken", 32'(upd_taken), 32'(tk));
        chk("upd_target", upd_target, tgt);
        chk("branch_cnt", 32'(branch_cnt), 32'(sat(model_br)));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(sat(model_mis)));

        if (!mis) begin
            chk("no_flush", 32'(flush), 32'd0);
            chk("ready_after_hit", 32'(res_ready), 32'd1);
            return;
        end

        for (int i = 0; i < FC; i++) begin
            chk("flush_on", 32'(flush), 32'd1);
            chk("rv_off_in_flush", 32'(redirect_valid), 32'd0);
            chk("ready_flush", 32'(res_ready), 32'd0);
            if (i > 0) chk("upd_single", 32'(upd_valid), 32'd0);
            redirect_ready = 1'($urandom_range(0, 1));
            step();
        end
        for (int d = 0; d <= rr_delay; d++) begin
            chk("rv_on", 32'(redirect_valid), 32'd1);
            chk("flush_off_in_redir", 32'(flush), 32'd0);
            chk("redirect_pc", redirect_pc, good);
            chk("ready_redir", 32'(res_ready), 32'd0);
            redirect_ready = (d == rr_delay);
            step();
        end
        redirect_ready = 1'b0;
        chk("rv_released", 32'(redirect_valid), 32'd0);
        chk("ready_back", 32'(res_ready), 32'd1);
        chk("no_accept_in_redir", 32'(branch_cnt), 32'(sat(model_br)));
        if (hold) chk("no_upd_in_redir", 32'(upd_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] r_pc, r_tgt, r_ptgt;
        logic        r_tk, r_ptk;

        nRST = 1'b0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        res_pc = '0; pred_taken = 1'b0; pred_target = '0; redirect_ready = 1'b0;
        step(); step();
        chk("rst_ready", 32'(res_ready), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_upd", 32'(upd_valid), 32'd0);
        chk("rst_bcnt", 32'(branch_cnt), 32'd0);
        chk("rst_mcnt", 32'(mispred_cnt), 32'd0);
        nRST = 1'b1;
        step();

        // Correct prediction, direction mispredict, target mispredict with
        // back-pressure, fall-through wrap-around.
        send(32'h100, 1'b1, 32'h164, 1'b1, 32'h164, 0, 1'b0);
        send(32'h200, 1'b0, 32'h260, 1'b1, 32'h260, 0, 1'b0);
        send(32'h280, 1'b1, 32'h300, 1'b1, 32'h310, 5, 1'b0);
        send(32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 32'h40, 1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 30; n++) begin
            r_pc   = $urandom & 32'hFFFF_FFFC;
            r_tgt  = $urandom & 32'hFFFF_FFFC;
            r_tk   = 1'($urandom_range(0, 1));
            r_ptk  = 1'($urandom_range(0, 1));
            r_ptgt = ($urandom_range(0, 1) == 1) ? r_tgt : ($urandom & 32'hFFFF_FFFC);
            send(r_pc, r_tk, r_tgt, r_ptk, r_ptgt, $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 3) == 0) step();
        end

        // Reset in the second flush cycle.
        res_pc = 32'h500; res_taken = 1'b0; res_target = 32'h0;
        pred_taken = 1'b1; pred_target = 32'h0; res_valid = 1'b1;
        step();
        accepted_total++;
        res_valid = 1'b0;
        chk("pre_rst_flush1", 32'(flush), 32'd1);
        step();
        chk("pre_rst_flush2", 32'(flush), 32'd1);
        nRST = 1'b0;
        step();
        chk("midrst_flush", 32'(flush), 32'd0);
        chk("midrst_rv", 32'(redirect_valid), 32'd0);
        chk("midrst_bcnt", 32'(branch_cnt), 32'd0);
        chk("midrst_mcnt", 32'(mispred_cnt), 32'd0);
        chk("midrst_ready", 32'(res_ready), 32'd0);
        step();
        chk("midrst_ready2", 32'(res_ready), 32'd0);
        nRST = 1'b1;
        step();
        chk("postrst_ready", 32'(res_ready), 32'd1);
        chk("postrst_rv", 32'(redirect_valid), 32'd0);
        model_br = 0; model_mis = 0;

        // Saturation: 20 back-to-back mispredicts with res_valid never dropped.
        for (int n = 0; n < 20; n++)
            send(32'h1000 + 32'(n * 4), 1'b0, 32'h0, 1'b1, 32'h0, 0, 1'b1);
        res_valid = 1'b0;
        step();
        chk("sat_bcnt", 32'(branch_cnt), 32'(SAT));
        chk("sat_mcnt", 32'(mispred_cnt), 32'(SAT));
        chk("upd_pulse_total", 32'(upd_pulses), 32'(accepted_total));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
